// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Opcode encodings and flag bundle shared by the pipelined ALU.
// Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    typedef struct packed {
        logic carry;
        logic zero;
        logic negative;
        logic overflow;
    } alu_flags_t;

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module   : alu_core
// Brief    : Combinational WIDTH-bit ALU producing result, carry and overflow.
// Revision : 1.0  initial release
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH:0] w_add;
    logic [WIDTH:0] w_sub;

    // Subtract as a + ~b + 1 so the top bit reads as "no borrow".
    assign w_add = {1'b0, a} + {1'b0, b};
    assign w_sub = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (sel)
            OP_ADD: begin
                result   = w_add[WIDTH-1:0];
                carry    = w_add[WIDTH];
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result   = w_sub[WIDTH-1:0];
                carry    = w_sub[WIDTH];
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_SHL: begin
                result = {a[WIDTH-2:0], 1'b0};
                carry  = a[WIDTH-1];
            end
            OP_SHR: begin
                result = {1'b0, a[WIDTH-1:1]};
                carry  = a[0];
            end
            OP_NOT: result = ~a;
            default: result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe
// Brief    : Two-stage valid/ready ALU pipeline with accumulator operand.
// Revision : 1.0  initial release
// ============================================================================
module alu_pipe
    import alu_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] ACC_RESET = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALU_Sel,
    input  logic             Use_Acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             CarryOut,
    output logic             Zero,
    output logic             Negative,
    output logic             Overflow
);

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [2:0]       r_s1_sel;
    logic             r_s1_use_acc;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    alu_flags_t       r_flags;
    logic [WIDTH-1:0] r_acc;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic [WIDTH-1:0] w_a_eff;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_ovf;

    assign w_s2_adv = !r_out_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    // The accumulator is sampled at the same edge S2 loads, so chained beats see the fresh value.
    assign w_a_eff  = r_s1_use_acc ? r_acc : r_s1_a;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a        (w_a_eff),
        .b        (r_s1_b),
        .sel      (r_s1_sel),
        .result   (w_res),
        .carry    (w_carry),
        .overflow (w_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid   <= 1'b0;
            r_s1_a       <= '0;
            r_s1_b       <= '0;
            r_s1_sel     <= OP_ADD;
            r_s1_use_acc <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_a       <= A;
                r_s1_b       <= B;
                r_s1_sel     <= ALU_Sel;
                r_s1_use_acc <= Use_Acc;
            end
        end
    end

    // Result and flags only move on a valid beat; a bubble just drops out_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
            r_acc       <= ACC_RESET;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result         <= w_res;
                r_flags.carry    <= w_carry;
                r_flags.zero     <= (w_res == '0);
                r_flags.negative <= w_res[WIDTH-1];
                r_flags.overflow <= w_ovf;
                r_acc            <= w_res;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign Result    = r_result;
    assign CarryOut  = r_flags.carry;
    assign Zero      = r_flags.zero;
    assign Negative  = r_flags.negative;
    assign Overflow  = r_flags.overflow;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_pipe
// Brief    : Table-driven scoreboard bench for the two-stage ALU pipeline.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_pipe;

    typedef struct {
        logic [2:0] sel;
        logic       use_acc;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [3:0] cznv;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic [2:0] ALU_Sel;
    logic       Use_Acc;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] Result;
    logic       CarryOut;
    logic       Zero;
    logic       Negative;
    logic       Overflow;

    int   n_cmp = 0;
    int   n_err = 0;
    int   n_acc = 0;
    int   n_out = 0;
    int   acc0;
    vec_t sb[$];
    vec_t vecs[20];

    always #5 clk = ~clk;

    alu_pipe #(
        .WIDTH     (8),
        .ACC_RESET (8'h00)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .ALU_Sel   (ALU_Sel),
        .Use_Acc   (Use_Acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .CarryOut  (CarryOut),
        .Zero      (Zero),
        .Negative  (Negative),
        .Overflow  (Overflow)
    );

    function automatic vec_t mk(input logic [2:0] sel, input logic ua, input logic [7:0] a,
                                input logic [7:0] b, input logic [7:0] res, input logic [3:0] cznv);
        vec_t v;
        v.sel = sel; v.use_acc = ua; v.a = a; v.b = b; v.res = res; v.cznv = cznv;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat is taken.
    task automatic send(input vec_t v, input bit track);
        bit ok;
        ok = 1'b0;
        A = v.a; B = v.b; ALU_Sel = v.sel; Use_Acc = v.use_acc; in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: in_ready stuck at 0, expected 1");
        end else begin
            if (track) sb.push_back(v);
            n_acc++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk); #1;
        end
        check(name, 32'(sb.size()), 32'd0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_output: got Result %0h, expected no beat", Result);
            end else begin
                vec_t e;
                e = sb.pop_front();
                check($sformatf("beat%0d_result", n_out), 32'(Result), 32'(e.res));
                check($sformatf("beat%0d_carry", n_out), 32'(CarryOut), 32'(e.cznv[3]));
                check($sformatf("beat%0d_zero", n_out), 32'(Zero), 32'(e.cznv[2]));
                check($sformatf("beat%0d_neg", n_out), 32'(Negative), 32'(e.cznv[1]));
                check($sformatf("beat%0d_ovf", n_out), 32'(Overflow), 32'(e.cznv[0]));
                n_out++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //               sel     acc  A      B      Result  {C,Z,N,V}
        vecs[0]  = mk(3'b000, 1'b0, 8'h7F, 8'h01, 8'h80, 4'b0011);
        vecs[1]  = mk(3'b001, 1'b0, 8'h05, 8'h05, 8'h00, 4'b1100);
        vecs[2]  = mk(3'b001, 1'b0, 8'h03, 8'h05, 8'hFE, 4'b0010);
        vecs[3]  = mk(3'b010, 1'b0, 8'hC3, 8'hA5, 8'h81, 4'b0010);
        vecs[4]  = mk(3'b011, 1'b0, 8'hC3, 8'hA5, 8'hE7, 4'b0010);
        vecs[5]  = mk(3'b100, 1'b0, 8'hC3, 8'hA5, 8'h66, 4'b0000);
        vecs[6]  = mk(3'b101, 1'b0, 8'hC3, 8'hA5, 8'h86, 4'b1010);
        vecs[7]  = mk(3'b110, 1'b0, 8'hC3, 8'hA5, 8'h61, 4'b1000);
        vecs[8]  = mk(3'b111, 1'b0, 8'hC3, 8'hA5, 8'h3C, 4'b0000);
        vecs[9]  = mk(3'b000, 1'b0, 8'h01, 8'h02, 8'h03, 4'b0000);
        vecs[10] = mk(3'b001, 1'b0, 8'h10, 8'h01, 8'h0F, 4'b1000);
        vecs[11] = mk(3'b100, 1'b0, 8'hFF, 8'h0F, 8'hF0, 4'b0010);
        vecs[12] = mk(3'b011, 1'b0, 8'h00, 8'h00, 8'h00, 4'b0100);
        vecs[13] = mk(3'b000, 1'b1, 8'hEE, 8'h10, 8'h10, 4'b0000);
        vecs[14] = mk(3'b000, 1'b1, 8'hEE, 8'h10, 8'h20, 4'b0000);
        vecs[15] = mk(3'b000, 1'b1, 8'hEE, 8'h10, 8'h30, 4'b0000);
        vecs[16] = mk(3'b101, 1'b1, 8'hEE, 8'h00, 8'h60, 4'b0000);
        vecs[17] = mk(3'b000, 1'b1, 8'hEE, 8'h55, 8'h00, 4'b0000);
        vecs[18] = mk(3'b000, 1'b1, 8'hEE, 8'h55, 8'h00, 4'b0000);
        vecs[19] = mk(3'b000, 1'b1, 8'hEE, 8'h01, 8'h01, 4'b0000);

        reset = 1'b1; in_valid = 1'b0; A = '0; B = '0; ALU_Sel = '0; Use_Acc = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(Result), 32'd0);
        check("rst_flags", 32'({CarryOut, Zero, Negative, Overflow}), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Single ADD with overflow and exact two-cycle latency
        send(vecs[0], 1'b1);
        @(negedge clk);
        check("t1_lat_cycle1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("t1_lat_cycle2", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        wait_drain("t1_drain");

        // Back-to-back subtracts, then the logic/shift opcode sweep
        for (int k = 1; k <= 8; k++) send(vecs[k], 1'b1);
        wait_drain("t2_t3_drain");

        // Backpressure: consumer stalls for 5 cycles while 4 beats are offered
        acc0 = n_acc;
        out_ready = 1'b0;
        fork
            begin
                for (int k = 9; k <= 12; k++) send(vecs[k], 1'b1);
            end
            begin
                repeat (5) begin
                    @(negedge clk);
                    if (out_valid) begin
                        check("t4_hold_result", 32'(Result), 32'(vecs[9].res));
                        check("t4_hold_flags", 32'({CarryOut, Zero, Negative, Overflow}),
                              32'(vecs[9].cznv));
                    end
                end
                check("t4_accepts_stalled", 32'(n_acc - acc0), 32'd2);
                check("t4_in_ready_low", 32'(in_ready), 32'd0);
                check("t4_out_valid_held", 32'(out_valid), 32'd1);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        wait_drain("t4_drain");
        check("t4_all_emitted", 32'(n_out), 32'd13);

        // Accumulator chain from a fresh reset
        pulse_reset();
        for (int k = 13; k <= 16; k++) send(vecs[k], 1'b1);
        wait_drain("t5_drain");

        // Reset with two beats in flight discards them and restores ACC_RESET
        send(vecs[17], 1'b0);
        send(vecs[18], 1'b0);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("t6_flush_out_valid", 32'(out_valid), 32'd0);
        check("t6_flush_result", 32'(Result), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("t6_no_stale", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        send(vecs[19], 1'b1);
        wait_drain("t6_drain");
        check("t6_total_outputs", 32'(n_out), 32'd18);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
